// File: rtl/ctrl_seq.sv
// ctrl_seq: multi-cycle IDLE/FETCH/DECODE/EXEC sequencer for a small RV32I subset.
// Fetches one word, registers datapath controls from it, then advances the PC.
module ctrl_seq #(
    parameter int                 A_WIDTH  = 5,
    parameter int                 D_WIDTH  = 32,
    parameter logic [D_WIDTH-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               run,
    output logic               imem_req,
    output logic [D_WIDTH-1:0] imem_addr,
    input  logic [31:0]        imem_rdata,
    input  logic               imem_valid,
    input  logic               EQ,
    output logic               ALUsrc,
    output logic [2:0]         ALUctrl,
    output logic               RegWrite,
    output logic [A_WIDTH-1:0] rs1,
    output logic [A_WIDTH-1:0] rs2,
    output logic [A_WIDTH-1:0] rd,
    output logic [D_WIDTH-1:0] ImmOp,
    output logic [D_WIDTH-1:0] pc,
    output logic               illegal
);

    typedef enum logic [1:0] {IDLE, FETCH, DECODE, EXEC} state_t;

    localparam logic [6:0] OP_R = 7'b0110011;
    localparam logic [6:0] OP_I = 7'b0010011;
    localparam logic [6:0] OP_B = 7'b1100011;

    state_t             state;
    logic [31:0]        instr;
    logic               is_beq;
    logic               is_bne;
    logic               br_taken;

    logic [6:0]         funct7;
    logic [2:0]         funct3;
    logic [D_WIDTH-1:0] imm_i;
    logic [D_WIDTH-1:0] imm_b;

    logic               dec_legal;
    logic               dec_src;
    logic               dec_wr;
    logic               dec_beq;
    logic               dec_bne;
    logic [2:0]         dec_ctrl;
    logic [D_WIDTH-1:0] dec_imm;

    assign funct7    = instr[31:25];
    assign funct3    = instr[14:12];
    assign imm_i     = {{(D_WIDTH-12){instr[31]}}, instr[31:20]};
    assign imm_b     = {{(D_WIDTH-13){instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imem_addr = pc;
    assign br_taken  = (is_beq & EQ) | (is_bne & ~EQ);

    // NOTE: every decode output gets a default first, so no path through the cases can infer a latch.
    always_comb begin
        dec_legal = 1'b0;
        dec_src   = 1'b0;
        dec_ctrl  = 3'b000;
        dec_imm   = '0;
        dec_beq   = 1'b0;
        dec_bne   = 1'b0;
        case (instr[6:0])
            OP_R: begin
                dec_legal = 1'b1;
                case ({funct7, funct3})
                    {7'b0000000, 3'b000}: dec_ctrl = 3'b000;
                    {7'b0100000, 3'b000}: dec_ctrl = 3'b001;
                    {7'b0000000, 3'b111}: dec_ctrl = 3'b010;
                    {7'b0000000, 3'b110}: dec_ctrl = 3'b011;
                    {7'b0000000, 3'b010}: dec_ctrl = 3'b101;
                    default:              dec_legal = 1'b0;
                endcase
            end
            OP_I: begin
                dec_legal = 1'b1;
                dec_src   = 1'b1;
                dec_imm   = imm_i;
                case (funct3)
                    3'b000:  dec_ctrl = 3'b000;
                    3'b111:  dec_ctrl = 3'b010;
                    3'b110:  dec_ctrl = 3'b011;
                    default: dec_legal = 1'b0;
                endcase
            end
            OP_B: begin
                dec_ctrl  = 3'b001;
                dec_imm   = imm_b;
                dec_beq   = (funct3 == 3'b000);
                dec_bne   = (funct3 == 3'b001);
                dec_legal = dec_beq | dec_bne;
            end
            default: ;
        endcase
        // Unsupported words become a NOP with neutral ALU controls.
        if (!dec_legal) begin
            dec_src  = 1'b0;
            dec_ctrl = 3'b000;
            dec_imm  = '0;
        end
        dec_wr = dec_legal && (instr[6:0] == OP_R || instr[6:0] == OP_I) && (instr[11:7] != 5'd0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            pc       <= RESET_PC;
            instr    <= '0;
            imem_req <= 1'b0;
            RegWrite <= 1'b0;
            ALUsrc   <= 1'b0;
            ALUctrl  <= 3'b000;
            rs1      <= '0;
            rs2      <= '0;
            rd       <= '0;
            ImmOp    <= '0;
            illegal  <= 1'b0;
            is_beq   <= 1'b0;
            is_bne   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (run) begin
                        state    <= FETCH;
                        imem_req <= 1'b1;
                    end
                end
                FETCH: begin
                    if (imem_valid) begin
                        instr    <= imem_rdata;
                        imem_req <= 1'b0;
                        state    <= DECODE;
                    end
                end
                DECODE: begin
                    rs1      <= A_WIDTH'(instr[19:15]);
                    rs2      <= A_WIDTH'(instr[24:20]);
                    rd       <= A_WIDTH'(instr[11:7]);
                    ALUsrc   <= dec_src;
                    ALUctrl  <= dec_ctrl;
                    ImmOp    <= dec_imm;
                    RegWrite <= dec_wr;
                    is_beq   <= dec_beq;
                    is_bne   <= dec_bne;
                    if (!dec_legal) illegal <= 1'b1;
                    state    <= EXEC;
                end
                EXEC: begin
                    RegWrite <= 1'b0;
                    pc       <= br_taken ? pc + ImmOp : pc + D_WIDTH'(4);
                    if (run) begin
                        state    <= FETCH;
                        imem_req <= 1'b1;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ctrl_seq.sv
// Bench for ctrl_seq: directed instruction cases plus a randomized instruction stream,
// compared every cycle against a transaction-level model of fetch/decode/execute.
module tb_ctrl_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        run;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_valid;
    logic        EQ;
    logic        ALUsrc;
    logic [2:0]  ALUctrl;
    logic        RegWrite;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] ImmOp;
    logic [31:0] pc;
    logic        illegal;

    ctrl_seq #(.A_WIDTH(5), .D_WIDTH(32), .RESET_PC(32'h0)) dut (
        .clk(clk), .rst(rst), .run(run),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata), .imem_valid(imem_valid),
        .EQ(EQ), .ALUsrc(ALUsrc), .ALUctrl(ALUctrl), .RegWrite(RegWrite),
        .rs1(rs1), .rs2(rs2), .rd(rd), .ImmOp(ImmOp), .pc(pc), .illegal(illegal)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        legal;
        logic        writes;
        logic        branch;
        logic        br_ne;
        logic        src;
        logic [2:0]  ctrl;
        logic [31:0] imm;
        logic        rs2_ok;
        logic        rd_ok;
        logic        imm_ok;
    } dec_t;

    int checks   = 0;
    int failures = 0;

    logic [31:0] m_pc;
    logic        m_ill;
    logic        exp_chk, exp_req, exp_wr, exp_exec;
    dec_t        exp_dec;
    logic [31:0] exp_word;

    int          req_cnt = 0;
    logic [4:0]  cap_rs1, cap_rs2, cap_rd;
    logic [31:0] cap_imm;
    logic        cap_src, cap_wr;
    logic [2:0]  cap_ctrl;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Instruction meaning straight from the ISA tables, immediates via integer arithmetic.
    function automatic dec_t model_decode(input logic [31:0] w);
        dec_t d;
        int f3    = int'(w[14:12]);
        int f7    = int'(w[31:25]);
        int imm_i = int'(w[31:20]) - (w[31] ? 4096 : 0);
        int imm_b = (w[31] ? -4096 : 0) + int'(w[7]) * 2048 + int'(w[30:25]) * 32 + int'(w[11:8]) * 2;
        d = '0;
        case (w[6:0])
            7'h33: begin
                d.rs2_ok = 1'b1;
                d.rd_ok  = 1'b1;
                if      (f7 == 0  && f3 == 0) begin d.legal = 1'b1; d.ctrl = 3'd0; end
                else if (f7 == 32 && f3 == 0) begin d.legal = 1'b1; d.ctrl = 3'd1; end
                else if (f7 == 0  && f3 == 7) begin d.legal = 1'b1; d.ctrl = 3'd2; end
                else if (f7 == 0  && f3 == 6) begin d.legal = 1'b1; d.ctrl = 3'd3; end
                else if (f7 == 0  && f3 == 2) begin d.legal = 1'b1; d.ctrl = 3'd5; end
                d.writes = d.legal && (w[11:7] != 5'd0);
            end
            7'h13: begin
                d.src    = 1'b1;
                d.rd_ok  = 1'b1;
                d.imm_ok = 1'b1;
                d.imm    = 32'(imm_i);
                if      (f3 == 0) begin d.legal = 1'b1; d.ctrl = 3'd0; end
                else if (f3 == 7) begin d.legal = 1'b1; d.ctrl = 3'd2; end
                else if (f3 == 6) begin d.legal = 1'b1; d.ctrl = 3'd3; end
                d.writes = d.legal && (w[11:7] != 5'd0);
            end
            7'h63: begin
                d.legal  = (f3 == 0 || f3 == 1);
                d.branch = 1'b1;
                d.br_ne  = (f3 == 1);
                d.ctrl   = 3'd1;
                d.rs2_ok = 1'b1;
                d.imm_ok = 1'b1;
                d.imm    = 32'(imm_b);
            end
            default: d.legal = 1'b0;
        endcase
        return d;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        logic [6:0]  rf7 [5];
        logic [2:0]  rf3 [5];
        logic [2:0]  if3 [3];
        int          k;
        rf7 = '{7'h00, 7'h20, 7'h00, 7'h00, 7'h00};
        rf3 = '{3'd0, 3'd0, 3'd7, 3'd6, 3'd2};
        if3 = '{3'd0, 3'd7, 3'd6};
        w = $urandom;
        k = int'($urandom_range(0, 4));
        case ($urandom_range(0, 9))
            0, 1, 2: begin w[6:0] = 7'h33; w[31:25] = rf7[k]; w[14:12] = rf3[k]; end
            3, 4, 5: begin w[6:0] = 7'h13; w[14:12] = if3[k % 3]; end
            6, 7, 8: begin w[6:0] = 7'h63; w[14:12] = 3'($urandom_range(0, 1)); end
            default: begin
                case (k)
                    0: begin w[6:0] = 7'h33; w[31:25] = 7'h01; end
                    1: begin w[6:0] = 7'h13; w[14:12] = 3'd1; end
                    2: begin w[6:0] = 7'h63; w[14:12] = 3'd4; end
                    default: w[6:0] = 7'h03;
                endcase
            end
        endcase
        if ($urandom_range(0, 7) == 0) w[11:7] = 5'd0;
        return w;
    endfunction

    always @(negedge clk) begin
        if (exp_chk) begin
            if (imem_req) req_cnt++;
            check("imem_req", 32'(imem_req), 32'(exp_req));
            if (exp_req) check("imem_addr", imem_addr, m_pc);
            check("pc", pc, m_pc);
            check("RegWrite", 32'(RegWrite), 32'(exp_wr));
            check("illegal", 32'(illegal), 32'(m_ill));
            if (exp_exec) begin
                cap_rs1 = rs1; cap_rs2 = rs2; cap_rd = rd; cap_imm = ImmOp;
                cap_src = ALUsrc; cap_ctrl = ALUctrl; cap_wr = RegWrite;
                if (exp_dec.legal) begin
                    check("rs1", 32'(rs1), 32'(exp_word[19:15]));
                    check("ALUsrc", 32'(ALUsrc), 32'(exp_dec.src));
                    check("ALUctrl", 32'(ALUctrl), 32'(exp_dec.ctrl));
                    if (exp_dec.rs2_ok) check("rs2", 32'(rs2), 32'(exp_word[24:20]));
                    if (exp_dec.rd_ok)  check("rd", 32'(rd), 32'(exp_word[11:7]));
                    if (exp_dec.imm_ok) check("ImmOp", ImmOp, exp_dec.imm);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cycles(input int n);
        run = 1'b0; exp_req = 1'b0; exp_wr = 1'b0; exp_exec = 1'b0;
        repeat (n) begin
            imem_valid = 1'($urandom_range(0, 1));
            imem_rdata = $urandom;
            EQ         = 1'($urandom_range(0, 1));
            tick();
        end
    endtask

    task automatic start_run();
        run = 1'b1;
        imem_valid = 1'($urandom_range(0, 1));
        tick();
        exp_req = 1'b1;
    endtask

    // Called in the first FETCH cycle; returns in the cycle after EXEC (FETCH or IDLE).
    task automatic do_instr(input logic [31:0] w, input int delay, input logic eq,
                            input int fetch_run, input logic run_after);
        dec_t d = model_decode(w);
        for (int i = 0; i <= delay; i++) begin
            exp_req = 1'b1; exp_wr = 1'b0; exp_exec = 1'b0;
            imem_valid = (i == delay);
            imem_rdata = (i == delay) ? w : $urandom;
            run = (fetch_run == 2) ? 1'($urandom_range(0, 1)) : 1'(fetch_run);
            EQ  = 1'($urandom_range(0, 1));
            tick();
        end
        exp_req = 1'b0;
        imem_valid = 1'($urandom_range(0, 1));
        imem_rdata = $urandom;
        run = 1'($urandom_range(0, 1));
        tick();
        exp_dec = d; exp_word = w; exp_exec = 1'b1; exp_wr = d.writes;
        if (!d.legal) m_ill = 1'b1;
        EQ = eq; run = run_after;
        imem_valid = 1'($urandom_range(0, 1));
        tick();
        exp_exec = 1'b0; exp_wr = 1'b0; exp_req = run_after;
        m_pc = (d.legal && d.branch && (eq != d.br_ne)) ? m_pc + d.imm : m_pc + 32'd4;
    endtask

    initial begin
        int base;
        logic ra;
        rst = 1'b0; run = 1'b0; imem_valid = 1'b0; imem_rdata = '0; EQ = 1'b0;
        exp_chk = 1'b0; exp_req = 1'b0; exp_wr = 1'b0; exp_exec = 1'b0;
        m_pc = 32'h0; m_ill = 1'b0; exp_dec = '0; exp_word = '0;

        #1 rst = 1'b1;
        #1;
        check("rst_pc", pc, 32'h0);
        check("rst_req", 32'(imem_req), 32'h0);
        check("rst_regwrite", 32'(RegWrite), 32'h0);
        check("rst_illegal", 32'(illegal), 32'h0);
        check("rst_immop", ImmOp, 32'h0);
        tick(); tick();
        rst = 1'b0;
        exp_chk = 1'b1;
        idle_cycles(2);

        start_run();
        base = req_cnt;
        do_instr(32'h00500513, 0, 1'b0, 1, 1'b1);
        check("addi_rs1", 32'(cap_rs1), 32'd0);
        check("addi_rd", 32'(cap_rd), 32'd10);
        check("addi_imm", cap_imm, 32'd5);
        check("addi_src", 32'(cap_src), 32'd1);
        check("addi_ctrl", 32'(cap_ctrl), 32'd0);
        check("addi_wr", 32'(cap_wr), 32'd1);
        check("addi_pc", pc, 32'd4);
        check("addi_reqcycles", 32'(req_cnt - base), 32'd1);

        base = req_cnt;
        do_instr(32'h002081B3, 2, 1'b0, 1, 1'b1);
        check("add_reqcycles", 32'(req_cnt - base), 32'd3);
        check("add_rs1", 32'(cap_rs1), 32'd1);
        check("add_rs2", 32'(cap_rs2), 32'd2);
        check("add_rd", 32'(cap_rd), 32'd3);
        check("add_src", 32'(cap_src), 32'd0);
        check("add_wr", 32'(cap_wr), 32'd1);
        check("add_pc", pc, 32'd8);

        do_instr(32'hFE051EE3, 0, 1'b0, 1, 1'b1);
        check("bne_taken_pc", pc, 32'd4);
        check("bne_wr", 32'(cap_wr), 32'd0);
        check("bne_ctrl", 32'(cap_ctrl), 32'd1);
        do_instr(32'h00500513, 1, 1'b0, 1, 1'b1);
        do_instr(32'hFE051EE3, 0, 1'b1, 1, 1'b1);
        check("bne_not_taken_pc", pc, 32'd12);

        do_instr(32'h00000033, 0, 1'b0, 1, 1'b1);
        check("add_x0_wr", 32'(cap_wr), 32'd0);
        check("add_x0_pc", pc, 32'd16);
        do_instr(32'hFFFFFFFF, 0, 1'b0, 1, 1'b1);
        check("illegal_set", 32'(illegal), 32'd1);
        check("illegal_pc", pc, 32'd20);
        do_instr(32'h00500513, 0, 1'b0, 1, 1'b1);
        check("illegal_sticky", 32'(illegal), 32'd1);
        do_instr(32'hFE000CE3, 0, 1'b1, 1, 1'b1);
        check("beq_back_pc", pc, 32'h10);

        // Abort an instruction in DECODE with an asynchronous reset.
        exp_req = 1'b1; imem_valid = 1'b1; imem_rdata = 32'h00500513; run = 1'b1;
        tick();
        exp_chk = 1'b0; imem_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("midrst_pc", pc, 32'h0);
        check("midrst_regwrite", 32'(RegWrite), 32'h0);
        check("midrst_req", 32'(imem_req), 32'h0);
        check("midrst_illegal", 32'(illegal), 32'h0);
        check("midrst_rd", 32'(rd), 32'h0);
        tick();
        rst = 1'b0;
        m_pc = 32'h0; m_ill = 1'b0; exp_req = 1'b0; exp_wr = 1'b0; exp_exec = 1'b0;
        exp_chk = 1'b1;
        idle_cycles(3);

        start_run();
        do_instr(32'hFE000EE3, 0, 1'b1, 2, 1'b1);
        check("wrap_setup_pc", pc, 32'hFFFFFFFC);
        do_instr(32'h00500513, 1, 1'b0, 0, 1'b0);
        check("wrap_pc", pc, 32'h0);
        idle_cycles(2);
        check("drop_run_idle_req", 32'(imem_req), 32'h0);

        start_run();
        for (int n = 0; n < 200; n++) begin
            ra = ($urandom_range(0, 9) != 0);
            do_instr(rand_instr(), int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 2, ra);
            if (!ra) begin
                idle_cycles(int'($urandom_range(0, 2)));
                start_run();
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ctrl_seq.md
CTRL_SEQ -- requirements
Module: ctrl_seq

Interface
REQ-001 The block SHALL have a single clock and an asynchronous, active-high reset.
REQ-002 Parameters SHALL be: A_WIDTH, default 5, register address width; D_WIDTH, default 32, data/PC width; RESET_PC, default 0, PC value after reset.
REQ-003 Ports SHALL be:
- clk  in  1  clock
- rst  in  1  async active-high reset
- run  in  1  enable; starts and continues execution
- imem_req  out  1  fetch request
- imem_addr  out  D_WIDTH  fetch address (= pc)
- imem_rdata  in  32  instruction word
- imem_valid  in  1  imem_rdata valid this cycle
- EQ  in  1  ALU equality flag from datapath
- ALUsrc  out  1  1 = ImmOp operand, 0 = register operand
- ALUctrl  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt
- RegWrite  out  1  register-file write enable
- rs1, rs2, rd  out  A_WIDTH each  register addresses
- ImmOp  out  D_WIDTH  sign-extended immediate
- pc  out  D_WIDTH  current program counter
- illegal  out  1  sticky unsupported-instruction flag

Function
REQ-004 The FSM SHALL have states IDLE, FETCH, DECODE, EXEC.
REQ-005 IDLE -> FETCH when run=1; otherwise IDLE holds.
REQ-006 In FETCH, imem_req=1 and imem_addr=pc; the FSM SHALL hold until imem_valid=1 at a rising edge, then latch imem_rdata and go to DECODE. Minimum instruction latency: 3 cycles.
REQ-007 DECODE SHALL take one cycle and register rs1, rs2, rd, ImmOp, ALUsrc and ALUctrl from the latched word; these outputs SHALL stay stable through EXEC.
REQ-008 Supported instructions:
- R-type (opcode 0110011): ADD, SUB, AND, OR, SLT; ALUsrc=0.
- I-type (opcode 0010011): ADDI, ANDI, ORI; ALUsrc=1; ImmOp = sign-extended instr[31:20].
- B-type (opcode 1100011): BEQ, BNE; ALUsrc=0, ALUctrl=001; ImmOp = sign-extended {instr[31], instr[7], instr[30:25], instr[11:8], 0}.
REQ-009 RegWrite SHALL be 1 for exactly the one EXEC cycle of an R- or I-type instruction with rd != 0, and 0 at all other times.
REQ-010 At the end of EXEC, the PC SHALL update as follows:
- Taken branch: pc + ImmOp. BEQ is taken when EQ=1; BNE is taken when EQ=0. EQ is sampled in EXEC.
- Otherwise: pc + 4.
- PC arithmetic is modulo 2^D_WIDTH; wrap-around is permitted.
REQ-011 From EXEC, the FSM SHALL go to FETCH if run=1 and to IDLE if run=0. run is ignored in FETCH and DECODE; an in-flight instruction always completes.
REQ-012 An unsupported opcode or funct SHALL:
- set illegal=1, which stays set until reset;
- execute as a NOP with RegWrite=0 and pc + 4.
REQ-013 imem_valid outside FETCH SHALL be ignored.

Reset
REQ-014 On rst=1, the block SHALL immediately, without a clock edge:
- enter IDLE;
- set pc=RESET_PC;
- drive imem_req, RegWrite, ALUsrc, ALUctrl, rs1, rs2, rd, ImmOp and illegal to 0.
REQ-015 Reset asserted mid-instruction SHALL abort that instruction with no register write and no PC update.

Verification
REQ-016 Instruction 0x00500513 (addi x10,x0,5) with imem_valid in the first FETCH cycle -> in EXEC (cycle 3): rs1=0, rd=10, ImmOp=5, ALUsrc=1, ALUctrl=000, RegWrite=1; pc goes 0 -> 4.
REQ-017 Instruction 0x002081B3 (add x3,x1,x2) with imem_valid delayed by 2 cycles -> imem_req held for 3 cycles; then rs1=1, rs2=2, rd=3, ALUsrc=0, ALUctrl=000, RegWrite=1 for one cycle.
REQ-018 Instruction 0xFE051EE3 (bne x10,x0,-4) at pc=8:
- EQ=0 -> pc=4, RegWrite=0, ALUctrl=001.
- EQ=1 -> pc=12.
REQ-019 Instruction 0x00000033 (add x0,x0,x0) -> RegWrite stays 0; pc+4. Word 0xFFFFFFFF -> illegal=1 and stays 1 across later valid instructions; pc+4.
REQ-020 rst pulsed during DECODE after a fetch at pc=0x10 -> pc=RESET_PC, state IDLE, and RegWrite=0 without waiting for a clock edge.
REQ-021 run dropped during FETCH -> the current instruction completes and the FSM returns to IDLE; with pc=0xFFFFFFFC, a non-branch wraps pc to 0.
